// File: rtl/exp_prng_pkg.sv
// Shared constants, S1 stage record and elaboration-time inverse-CDF table
// builder for the multi-channel exponential PRNG.
package exp_prng_pkg;

   localparam logic [15:0] TAPS_16    = 16'hB400;
   localparam logic [31:0] TAPS_32    = 32'h80200003;
   localparam logic [31:0] SEED_BASE  = 32'h0000ACE1;
   localparam int          MAX_CH_WID = 4;
   localparam int          MAX_U_WID  = 16;

   typedef struct packed {
      logic                  valid;
      logic [MAX_CH_WID-1:0] ch;
      logic [MAX_U_WID-1:0]  u;
      logic [3:0]            shift;
   } s1_rec_t;

   // Entry k = min(2^x_wid-1, round(2^(x_wid-4) * -ln((k+0.5)/2^u_wid)))
   function automatic logic [31:0] lut_entry(input int k, input int u_wid, input int x_wid);
      real p_v;
      real v_v;
      int  r_v;
      int  max_v;
      p_v   = (real'(k) + 0.5) / real'(32'sd1 << u_wid);
      v_v   = -$ln(p_v) * real'(32'sd1 << (x_wid - 32'sd4));
      r_v   = $rtoi(v_v + 0.5);
      max_v = (32'sd1 << x_wid) - 32'sd1;
      if (r_v > max_v) begin
         return 32'(max_v);
      end else begin
         return 32'(r_v);
      end
   endfunction

endpackage

// File: rtl/exp_prng_lfsr.sv
// One channel's right-shifting Galois LFSR: seed load (zero forced to 1)
// has priority over an unrolled STEPS-step advance.
module exp_prng_lfsr
   import exp_prng_pkg::*;
#(
   parameter int             W         = 32,
   parameter int             STEPS     = 6,
   parameter logic [W-1:0]   RESET_VAL = W'(SEED_BASE)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] seed,
   input  logic         step,
   output logic [W-1:0] state
);

   localparam logic [W-1:0] TAPS = (W == 16) ? W'(TAPS_16) : W'(TAPS_32);

   function automatic logic [W-1:0] advance(input logic [W-1:0] s);
      logic [W-1:0] v;
      v = s;
      for (int i = 0; i < STEPS; i++) begin
         if (v[0]) begin
            v = (v >> 1) ^ TAPS;
         end else begin
            v = v >> 1;
         end
      end
      return v;
   endfunction

   // State register: reset, seed load, step, or hold
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RESET_VAL;
      end else if (load) begin
         state <= (seed == '0) ? {{(W-1){1'b0}}, 1'b1} : seed;
      end else if (step) begin
         state <= advance(state);
      end else begin
         state <= state;
      end
   end

endmodule

// File: rtl/exp_prng_multi.sv
// Multi-channel exponential PRNG: per-channel LFSRs, round-robin access to a
// shared inverse-CDF LUT, tagged valid/ready output. Optional per-channel
// rate shift is enabled by defining EXP_PRNG_SCALE_EN.
module exp_prng_multi
   import exp_prng_pkg::*;
#(
   parameter  int NUM_CH         = 4,
   parameter  int LFSR_STATE_WID = 32,
   parameter  int U_WID          = 6,
   parameter  int X_WID          = 16,
   localparam int CH_WID         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_CH-1:0]         ch_en_i,
   input  logic                      seed_we_i,
   input  logic [CH_WID-1:0]         seed_ch_i,
   input  logic [LFSR_STATE_WID-1:0] seed_i,
   input  logic                      shift_we_i,
   input  logic [3:0]                shift_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [X_WID-1:0]          data_o,
   output logic [CH_WID-1:0]         ch_o
);

   localparam int LUT_DEPTH = 32'sd1 << U_WID;

   logic                      adv_s;
   logic                      grant_valid_s;
   logic [CH_WID-1:0]         grant_s;
   logic [CH_WID-1:0]         rr_next_s;
   logic [CH_WID-1:0]         rr_r;
   logic [LFSR_STATE_WID-1:0] state_s [NUM_CH];
   logic [U_WID-1:0]          u_sel_s;
   logic [3:0]                shift_sel_s;
   s1_rec_t                   s1_r;
   logic [X_WID-1:0]          lut_s [LUT_DEPTH];
   logic [X_WID-1:0]          lut_val_s;
   logic [X_WID-1:0]          scaled_s;
   logic                      unused_s;

   assign adv_s = !valid_o || ready_i;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      exp_prng_lfsr #(
         .W         (LFSR_STATE_WID),
         .STEPS     (U_WID),
         .RESET_VAL (LFSR_STATE_WID'(SEED_BASE + 32'(c)))
      ) u_lfsr (
         .clk   (clk_i),
         .rst   (rst_i),
         .load  (seed_we_i && (seed_ch_i == CH_WID'(c))),
         .seed  (seed_i),
         .step  (adv_s && grant_valid_s && (grant_s == CH_WID'(c))),
         .state (state_s[c])
      );
   end

   for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
      localparam logic [X_WID-1:0] ENTRY = X_WID'(lut_entry(k, U_WID, X_WID));
      assign lut_s[k] = ENTRY;
   end

   // Round-robin search starting at rr, wrapping at NUM_CH
   always_comb begin
      int idx;
      grant_valid_s = 1'b0;
      grant_s       = '0;
      idx           = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_r) + i;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end else begin
            idx = idx;
         end
         if (!grant_valid_s && ch_en_i[idx]) begin
            grant_valid_s = 1'b1;
            grant_s       = CH_WID'(idx);
         end else begin
            grant_valid_s = grant_valid_s;
         end
      end
   end

   // Pointer moves one past the winner, wrapping to zero
   always_comb begin
      if (int'(grant_s) == NUM_CH - 1) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = grant_s + CH_WID'(1);
      end
   end

   assign u_sel_s = state_s[grant_s][U_WID-1:0];

`ifdef EXP_PRNG_SCALE_EN
   logic [3:0] shift_r [NUM_CH];

   // Per-channel rate-shift registers, written independently of adv
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (rst_i) begin
            shift_r[c] <= 4'd0;
         end else if (shift_we_i && (seed_ch_i == CH_WID'(c))) begin
            shift_r[c] <= shift_i;
         end else begin
            shift_r[c] <= shift_r[c];
         end
      end
   end

   assign shift_sel_s = shift_r[grant_s];
`else
   logic unused_shift_s;
   assign unused_shift_s = ^{shift_we_i, shift_i};
   assign shift_sel_s    = 4'd0;
`endif

   assign lut_val_s = lut_s[s1_r.u[U_WID-1:0]];
   assign scaled_s  = lut_val_s >> s1_r.shift;
   assign unused_s  = ^{s1_r.ch, s1_r.u};

   // S1 capture, output register and arbiter pointer; all frozen when adv is low
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_r    <= '0;
         valid_o <= 1'b0;
         data_o  <= '0;
         ch_o    <= '0;
         rr_r    <= '0;
      end else if (adv_s) begin
         s1_r.valid <= grant_valid_s;
         s1_r.ch    <= MAX_CH_WID'(grant_s);
         s1_r.u     <= MAX_U_WID'(u_sel_s);
         s1_r.shift <= shift_sel_s;
         valid_o    <= s1_r.valid;
         if (s1_r.valid) begin
            data_o <= scaled_s;
            ch_o   <= s1_r.ch[CH_WID-1:0];
         end else begin
            data_o <= data_o;
            ch_o   <= ch_o;
         end
         if (grant_valid_s) begin
            rr_r <= rr_next_s;
         end else begin
            rr_r <= rr_r;
         end
      end else begin
         s1_r    <= s1_r;
         valid_o <= valid_o;
         data_o  <= data_o;
         ch_o    <= ch_o;
         rr_r    <= rr_r;
      end
   end

endmodule

// File: tb/tb_exp_prng_multi.sv
// Directed self-checking bench for exp_prng_multi (default parameters).
module tb_exp_prng_multi;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [3:0]  ch_en_i;
   logic        seed_we_i;
   logic [1:0]  seed_ch_i;
   logic [31:0] seed_i;
   logic        shift_we_i;
   logic [3:0]  shift_i;
   logic        valid_o;
   logic        ready_i;
   logic [15:0] data_o;
   logic [1:0]  ch_o;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] m [4];

   always #5 clk = ~clk;

   exp_prng_multi dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .ch_en_i    (ch_en_i),
      .seed_we_i  (seed_we_i),
      .seed_ch_i  (seed_ch_i),
      .seed_i     (seed_i),
      .shift_we_i (shift_we_i),
      .shift_i    (shift_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_o     (data_o),
      .ch_o       (ch_o)
   );

   function automatic logic [31:0] ref_adv(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < 6; i++) begin
         if (v[0]) v = (v >> 1) ^ 32'h80200003;
         else      v = v >> 1;
      end
      return v;
   endfunction

   function automatic int ref_lut(input logic [5:0] u);
      real p;
      int  r;
      p = (real'(u) + 0.5) / 64.0;
      r = $rtoi(-$ln(p) * 4096.0 + 0.5);
      if (r > 65535) r = 65535;
      return r;
   endfunction

   task automatic test_reset;
      rst_i = 1'b1; ch_en_i = 4'b0000; ready_i = 1'b1;
      seed_we_i = 1'b0; seed_ch_i = 2'd0; seed_i = 32'd0;
      shift_we_i = 1'b0; shift_i = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
      n_cmp++; if (data_o !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", data_o); end
      n_cmp++; if (ch_o !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d expected 0", ch_o); end
   endtask

   task automatic test_stream;
      int c;
      int ed;
      for (int k = 0; k < 4; k++) m[k] = 32'h0000ACE1 + 32'(k);
      rst_i = 1'b0; ch_en_i = 4'b1111; ready_i = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %0b expected 0", valid_o); end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); @(negedge clk);
         c = i % 4;
         ed = ref_lut(m[c][5:0]);
         m[c] = ref_adv(m[c]);
         n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b expected 1", i, valid_o); end
         n_cmp++; if (ch_o !== 2'(c)) begin n_fail++; $display("FAIL stream_ch[%0d]: got %0d expected %0d", i, ch_o, c); end
         n_cmp++; if (data_o !== 16'(ed)) begin n_fail++; $display("FAIL stream_data[%0d]: got %0d expected %0d", i, data_o, ed); end
      end
      ch_en_i = 4'b0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0b expected 0", valid_o); end
   endtask

   task automatic test_seed_override;
      seed_we_i = 1'b1; seed_ch_i = 2'd2; seed_i = 32'h0000003F;
      @(posedge clk); @(negedge clk);
      seed_i = 32'h00000040; ch_en_i = 4'b0100;
      @(posedge clk); @(negedge clk);
      seed_we_i = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL seed3f_valid: got %0b expected 1", valid_o); end
      n_cmp++; if (ch_o !== 2'd2) begin n_fail++; $display("FAIL seed3f_ch: got %0d expected 2", ch_o); end
      n_cmp++; if (data_o !== 16'd32) begin n_fail++; $display("FAIL seed3f_data: got %0d expected 32", data_o); end
      ch_en_i = 4'b0000;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL seed40_valid: got %0b expected 1", valid_o); end
      n_cmp++; if (ch_o !== 2'd2) begin n_fail++; $display("FAIL seed40_ch: got %0d expected 2", ch_o); end
      n_cmp++; if (data_o !== 16'd19874) begin n_fail++; $display("FAIL seed40_data: got %0d expected 19874", data_o); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL seed_single: got %0b expected 0", valid_o); end
   endtask

   task automatic test_zero_seed;
      logic [31:0] mm;
      int ed;
      seed_we_i = 1'b1; seed_ch_i = 2'd1; seed_i = 32'd0;
      @(posedge clk); @(negedge clk);
      seed_we_i = 1'b0; ch_en_i = 4'b0010;
      mm = 32'd1;
      @(posedge clk);
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); @(negedge clk);
         ed = ref_lut(mm[5:0]);
         mm = ref_adv(mm);
         n_cmp++;
         if (valid_o !== 1'b1 || ch_o !== 2'd1 || data_o !== 16'(ed)) begin
            n_fail++;
            $display("FAIL zero_seed[%0d]: got v=%0b ch=%0d data=%0d expected v=1 ch=1 data=%0d", i, valid_o, ch_o, data_o, ed);
         end
      end
      ch_en_i = 4'b0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [31:0] mm;
      int e [4];
      mm = 32'h00001234;
      for (int j = 0; j < 4; j++) begin e[j] = ref_lut(mm[5:0]); mm = ref_adv(mm); end
      seed_we_i = 1'b1; seed_ch_i = 2'd0; seed_i = 32'h00001234;
      @(posedge clk); @(negedge clk);
      seed_we_i = 1'b0; ch_en_i = 4'b0001;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b1 || data_o !== 16'(e[0])) begin n_fail++; $display("FAIL bp_first: got v=%0b data=%0d expected v=1 data=%0d", valid_o, data_o, e[0]); end
      ready_i = 1'b0;
      for (int h = 0; h < 5; h++) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (valid_o !== 1'b1 || data_o !== 16'(e[0]) || ch_o !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v=%0b ch=%0d data=%0d expected v=1 ch=0 data=%0d", h, valid_o, ch_o, data_o, e[0]);
         end
      end
      ready_i = 1'b1;
      for (int j = 1; j < 4; j++) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (valid_o !== 1'b1 || data_o !== 16'(e[j]) || ch_o !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_release[%0d]: got v=%0b ch=%0d data=%0d expected v=1 ch=0 data=%0d", j, valid_o, ch_o, data_o, e[j]);
         end
      end
      ch_en_i = 4'b0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b expected 0", valid_o); end
   endtask

   task automatic test_midflight_reset;
      int ed;
      ch_en_i = 4'b1111; ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0b expected 0", valid_o); end
      n_cmp++; if (ch_o !== 2'd0 || data_o !== 16'd0) begin n_fail++; $display("FAIL mrst_out: got ch=%0d data=%0d expected ch=0 data=0", ch_o, data_o); end
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) m[k] = 32'h0000ACE1 + 32'(k);
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         ed = ref_lut(m[i][5:0]);
         m[i] = ref_adv(m[i]);
         n_cmp++;
         if (valid_o !== 1'b1 || ch_o !== 2'(i) || data_o !== 16'(ed)) begin
            n_fail++;
            $display("FAIL mrst_resume[%0d]: got v=%0b ch=%0d data=%0d expected v=1 ch=%0d data=%0d", i, valid_o, ch_o, data_o, i, ed);
         end
      end
      ch_en_i = 4'b0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_scale;
      logic [15:0] exp_d;
`ifdef EXP_PRNG_SCALE_EN
      exp_d = 16'd4;
`else
      exp_d = 16'd32;
`endif
      seed_we_i = 1'b1; shift_we_i = 1'b1; seed_ch_i = 2'd0;
      seed_i = 32'h0000003F; shift_i = 4'd3;
      @(posedge clk); @(negedge clk);
      seed_we_i = 1'b0; shift_we_i = 1'b0; ch_en_i = 4'b0001;
      @(posedge clk); @(negedge clk);
      ch_en_i = 4'b0000;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b1 || ch_o !== 2'd0) begin n_fail++; $display("FAIL scale_tag: got v=%0b ch=%0d expected v=1 ch=0", valid_o, ch_o); end
      n_cmp++; if (data_o !== exp_d) begin n_fail++; $display("FAIL scale_data: got %0d expected %0d", data_o, exp_d); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL scale_single: got %0b expected 0", valid_o); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_seed_override();
      test_zero_seed();
      test_backpressure();
      test_midflight_reset();
      test_scale();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
